// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer: one-hot state codes,
// command field constants and the latched-command record.
package i2c_pkg;

    localparam int unsigned ST_W = 8;

    localparam logic [ST_W-1:0] ST_IDLE   = 8'b0000_0001;
    localparam logic [ST_W-1:0] ST_DEV    = 8'b0000_0010;
    localparam logic [ST_W-1:0] ST_REG_HI = 8'b0000_0100;
    localparam logic [ST_W-1:0] ST_REG_LO = 8'b0000_1000;
    localparam logic [ST_W-1:0] ST_WDATA  = 8'b0001_0000;
    localparam logic [ST_W-1:0] ST_RDATA  = 8'b0010_0000;
    localparam logic [ST_W-1:0] ST_RESP   = 8'b0100_0000;
    localparam logic [ST_W-1:0] ST_GAP    = 8'b1000_0000;

    // States in which the engine is driven and the timeout counter runs
    localparam logic [ST_W-1:0] ST_ACTIVE_MASK = ST_DEV | ST_REG_HI | ST_REG_LO |
                                                 ST_WDATA | ST_RDATA;
    localparam logic [ST_W-1:0] ST_WR_MASK     = ST_DEV | ST_REG_HI | ST_REG_LO | ST_WDATA;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic [1:0] ADDR_LEN_1 = 2'd1;
    localparam logic [1:0] ADDR_LEN_2 = 2'd2;

    typedef struct packed {
        logic        rw;
        logic [6:0]  dev_addr;
        logic        addr2;
        logic [15:0] reg_addr;
        logic [7:0]  wdata;
    } i2c_cmd_t;

    function automatic logic [7:0] dev_byte(input logic [6:0] dev_addr, input logic rw);
        return {dev_addr, rw};
    endfunction

endpackage

// File: rtl/i2c_txn_timeout.sv
// Progress watchdog: counts cycles while enabled, cleared by the sequencer on
// accept and on every honoured engine pulse; expire is a level at the limit.
module i2c_txn_timeout #(
    parameter int unsigned TIMEOUT_CYC = 50_000,
    parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT_CYC));
    assign o_expire   = w_at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_txn_ctrl.sv
// Register-level command sequencer in front of the I2C byte engine: expands a
// command into device/register/data bytes and returns one response pulse.
module i2c_txn_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50_000,
    parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_dev_addr,
    input  logic        cmd_addr2,
    input  logic [15:0] cmd_reg_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        eng_wr_req,
    output logic        eng_rd_req,
    output logic [1:0]  eng_addr_len,
    output logic [7:0]  eng_wr_data,
    input  logic        eng_wr_done,
    input  logic        eng_rd_done,
    input  logic [7:0]  eng_rd_data
);

    logic [ST_W-1:0] r_state, w_state_nxt;
    i2c_cmd_t        r_cmd, w_cmd_nxt;
    logic [7:0]      r_wr_data, w_wr_data_nxt;
    logic [1:0]      r_addr_len, w_addr_len_nxt;
    logic            r_err, w_err_nxt;
    logic [7:0]      r_rdata, w_rdata_nxt;

    logic w_idle, w_active, w_accept;
    logic w_wr_hon, w_rd_hon, w_hon;
    logic w_expire, w_timeout;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_active = |(r_state & ST_ACTIVE_MASK);
    assign w_accept = w_idle && cmd_valid;

    // Only the pulse that matches the current byte phase counts as progress
    assign w_wr_hon  = eng_wr_done && |(r_state & ST_WR_MASK);
    assign w_rd_hon  = eng_rd_done && (r_state == ST_RDATA);
    assign w_hon     = w_wr_hon || w_rd_hon;
    assign w_timeout = w_expire && w_active && !w_hon;

    i2c_txn_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept || w_hon),
        .i_en     (w_active),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_nxt      = r_cmd;
        w_wr_data_nxt  = r_wr_data;
        w_addr_len_nxt = r_addr_len;
        w_err_nxt      = r_err;
        w_rdata_nxt    = r_rdata;

        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt       = ST_DEV;
                    w_cmd_nxt.rw       = cmd_rw;
                    w_cmd_nxt.dev_addr = cmd_dev_addr;
                    w_cmd_nxt.addr2    = cmd_addr2;
                    w_cmd_nxt.reg_addr = cmd_reg_addr;
                    w_cmd_nxt.wdata    = cmd_wdata;
                    w_wr_data_nxt      = dev_byte(cmd_dev_addr, cmd_rw);
                    w_addr_len_nxt     = cmd_addr2 ? ADDR_LEN_2 : ADDR_LEN_1;
                    w_err_nxt          = 1'b0;
                    w_rdata_nxt        = 8'h00;
                end
            end
            ST_DEV: begin
                if (eng_wr_done) begin
                    if (r_cmd.addr2) begin
                        w_state_nxt   = ST_REG_HI;
                        w_wr_data_nxt = r_cmd.reg_addr[15:8];
                    end else begin
                        w_state_nxt   = ST_REG_LO;
                        w_wr_data_nxt = r_cmd.reg_addr[7:0];
                    end
                end
            end
            ST_REG_HI: begin
                if (eng_wr_done) begin
                    w_state_nxt   = ST_REG_LO;
                    w_wr_data_nxt = r_cmd.reg_addr[7:0];
                end
            end
            ST_REG_LO: begin
                if (eng_wr_done) begin
                    if (r_cmd.rw == I2C_RW_READ) begin
                        w_state_nxt   = ST_RDATA;
                        w_wr_data_nxt = 8'h00;
                    end else begin
                        w_state_nxt   = ST_WDATA;
                        w_wr_data_nxt = r_cmd.wdata;
                    end
                end
            end
            ST_WDATA: begin
                if (eng_wr_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RDATA: begin
                if (eng_rd_done) begin
                    w_state_nxt = ST_RESP;
                    w_rdata_nxt = eng_rd_data;
                end
            end
            ST_RESP: w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_timeout) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_wr_data  <= 8'h00;
            r_addr_len <= ADDR_LEN_1;
            r_err      <= 1'b0;
            r_rdata    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_addr_len <= w_addr_len_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

    assign cmd_ready    = w_idle;
    assign busy         = !w_idle;
    assign rsp_valid    = (r_state == ST_RESP);
    assign rsp_err      = r_err;
    assign rsp_rdata    = r_rdata;
    assign eng_wr_req   = w_active && (r_cmd.rw == I2C_RW_WRITE);
    assign eng_rd_req   = w_active && (r_cmd.rw == I2C_RW_READ);
    assign eng_addr_len = r_addr_len;
    assign eng_wr_data  = r_wr_data;

endmodule
